// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cond_unit
//  Purpose  : Conditional-execution unit. Holds the architectural NZCV flag
//             register, evaluates the ARM-style 4-bit condition field against
//             it, and gates the decoder's write strobes so that an instruction
//             whose condition fails leaves no architectural side effects.
//             It can also count squashed instructions.
//
//  Ports    : clk         - system clock, rising edge
//             reset       - synchronous, active-high reset
//             Cond        - condition field, Instr[31:28]
//             ALUFlags    - {N,Z,C,V} from the ALU this cycle
//             FlagW       - flag write request ([1] N,Z  [0] C,V)
//             PCS         - decoder PC-write request
//             RegW        - decoder register-file write request
//             MemW        - decoder memory write request
//             NoWrite     - compare-class instruction, suppresses RegWrite
//             Stall       - hold flag register and squash counter
//             PCSrc       - gated PC write
//             RegWrite    - gated register-file write
//             MemWrite    - gated memory write
//             CondEx      - condition passed
//             Flags       - registered {N,Z,C,V}
//             SquashCount - saturating count of squashed instructions
//
//  Options  : COND_SQUASH_CNT_EN - when defined, the squash counter is built.
//             When undefined, SquashCount is tied to zero and no counter
//             flops exist; the port is kept so the interface is unchanged.
//
//  Revision : 1.0 - initial release
// ============================================================================
module cond_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   input  logic             Stall,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] SquashCount
);

   // -------------------------------------------------------------------------
   // Architectural flag register {N,Z,C,V}
   // -------------------------------------------------------------------------
   logic [3:0] r_flags;
   logic       w_cond_ex;
   logic [1:0] w_flag_write;

   logic w_n;
   logic w_z;
   logic w_c;
   logic w_v;

   assign w_n = r_flags[3];
   assign w_z = r_flags[2];
   assign w_c = r_flags[1];
   assign w_v = r_flags[0];

   // -------------------------------------------------------------------------
   // Condition evaluation. Uses only the registered flags, so flags produced
   // by the current instruction become visible to the next one.
   // -------------------------------------------------------------------------
   always_comb begin
      w_cond_ex = 1'b0;
      case (Cond)
         4'b0000: w_cond_ex = w_z;                      // EQ
         4'b0001: w_cond_ex = ~w_z;                     // NE
         4'b0010: w_cond_ex = w_c;                      // CS
         4'b0011: w_cond_ex = ~w_c;                     // CC
         4'b0100: w_cond_ex = w_n;                      // MI
         4'b0101: w_cond_ex = ~w_n;                     // PL
         4'b0110: w_cond_ex = w_v;                      // VS
         4'b0111: w_cond_ex = ~w_v;                     // VC
         4'b1000: w_cond_ex = w_c & ~w_z;               // HI
         4'b1001: w_cond_ex = ~w_c | w_z;               // LS
         4'b1010: w_cond_ex = ~(w_n ^ w_v);             // GE
         4'b1011: w_cond_ex = w_n ^ w_v;                // LT
         4'b1100: w_cond_ex = ~w_z & ~(w_n ^ w_v);      // GT
         4'b1101: w_cond_ex = w_z | (w_n ^ w_v);        // LE
         4'b1110: w_cond_ex = 1'b1;                     // AL
         default: w_cond_ex = 1'b0;                     // reserved: squash
      endcase
   end

   // -------------------------------------------------------------------------
   // Strobe gating (zero latency)
   // -------------------------------------------------------------------------
   assign CondEx       = w_cond_ex;
   assign PCSrc        = PCS  & w_cond_ex;
   assign RegWrite     = RegW & w_cond_ex & ~NoWrite;
   assign MemWrite     = MemW & w_cond_ex;
   assign w_flag_write = FlagW & {2{w_cond_ex}};

   // The N,Z and C,V halves are written independently; an unwritten half
   // keeps its previous value.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_flags <= 4'b0000;
      end else if (!Stall) begin
         if (w_flag_write[1]) begin
            r_flags[3:2] <= ALUFlags[3:2];
         end
         if (w_flag_write[0]) begin
            r_flags[1:0] <= ALUFlags[1:0];
         end
      end
   end

   assign Flags = r_flags;

   // -------------------------------------------------------------------------
   // Squash counter
   // -------------------------------------------------------------------------
`ifdef COND_SQUASH_CNT_EN
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   logic [CNT_W-1:0] r_squash_cnt;
   logic             w_any_req;
   logic             w_squash;

   // A squash is a failed instruction that actually requested a side
   // effect; instructions with every strobe low are not counted.
   assign w_any_req = PCS | RegW | MemW | (|FlagW);
   assign w_squash  = ~Stall & ~w_cond_ex & w_any_req;

   // Saturates at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_squash_cnt <= '0;
      end else if (w_squash && (r_squash_cnt != {CNT_W{1'b1}})) begin
         r_squash_cnt <= r_squash_cnt + c_cnt_one;
      end
   end

   assign SquashCount = r_squash_cnt;
`else
   assign SquashCount = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cond_unit
//  Purpose  : Self-checking bench for cond_unit. A table of directed vectors
//             covers every condition code and the strobe gating; hand-written
//             sequences cover reset, flag-write latency, split flag halves,
//             stall, squash counting and counter saturation (second instance
//             with CNT_W=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cond_unit;

   logic       clk;
   logic       reset;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS;
   logic       RegW;
   logic       MemW;
   logic       NoWrite;
   logic       Stall;

   logic        PCSrc,  RegWrite,  MemWrite,  CondEx;
   logic [3:0]  Flags;
   logic [15:0] SquashCount;

   logic        PCSrc2, RegWrite2, MemWrite2, CondEx2;
   logic [3:0]  Flags2;
   logic [1:0]  SquashCount2;

   int n_vec;
   int n_bad;

   cond_unit #(.CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
      .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
      .NoWrite(NoWrite), .Stall(Stall),
      .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .CondEx(CondEx), .Flags(Flags), .SquashCount(SquashCount)
   );

   cond_unit #(.CNT_W(2)) u_dut2 (
      .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
      .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
      .NoWrite(NoWrite), .Stall(Stall),
      .PCSrc(PCSrc2), .RegWrite(RegWrite2), .MemWrite(MemWrite2),
      .CondEx(CondEx2), .Flags(Flags2), .SquashCount(SquashCount2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] flags;
      logic [3:0] cond;
      logic       pcs;
      logic       regw;
      logic       memw;
      logic       nowr;
      logic       ex;
      logic       pcsrc;
      logic       regwr;
      logic       memwr;
   } vec_t;

   // Expected counter value in the current build.
   function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef COND_SQUASH_CNT_EN
      return v;
`else
      return 32'd0;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
      PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; Stall = 1'b0;
   endtask

   // Load the flag register with an always-executed full flag write.
   task automatic load_flags(input logic [3:0] f);
      idle();
      FlagW = 2'b11; ALUFlags = f;
      tick();
      FlagW = 2'b00;
   endtask

   vec_t tbl [22];

   initial begin
      n_vec = 0;
      n_bad = 0;

      //                flags    cond     pcs  regw memw nowr ex  pcsr regw memw
      tbl[0]  = '{4'b0100, 4'b0000, 1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0}; // EQ Z=1
      tbl[1]  = '{4'b0000, 4'b0001, 1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0}; // NE
      tbl[2]  = '{4'b0010, 4'b0010, 1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1}; // CS
      tbl[3]  = '{4'b0010, 4'b0011, 1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0}; // CC fail
      tbl[4]  = '{4'b1000, 4'b0100, 1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0}; // MI, NoWrite
      tbl[5]  = '{4'b1000, 4'b0101, 1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0}; // PL fail
      tbl[6]  = '{4'b0001, 4'b0110, 1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1}; // VS
      tbl[7]  = '{4'b0001, 4'b0111, 1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0}; // VC fail
      tbl[8]  = '{4'b0010, 4'b1000, 1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0}; // HI
      tbl[9]  = '{4'b0110, 4'b1000, 1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0}; // HI Z=1
      tbl[10] = '{4'b0110, 4'b1001, 1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0}; // LS
      tbl[11] = '{4'b0010, 4'b1001, 1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0}; // LS fail
      tbl[12] = '{4'b1000, 4'b1011, 1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0}; // LT
      tbl[13] = '{4'b1000, 4'b1010, 1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0}; // GE fail
      tbl[14] = '{4'b1000, 4'b1100, 1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0}; // GT fail
      tbl[15] = '{4'b1000, 4'b1101, 1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0}; // LE
      tbl[16] = '{4'b1001, 4'b1010, 1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1}; // GE N=V=1
      tbl[17] = '{4'b1001, 4'b1100, 1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0}; // GT
      tbl[18] = '{4'b1101, 4'b1100, 1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0}; // GT Z=1
      tbl[19] = '{4'b1111, 4'b1111, 1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0}; // reserved
      tbl[20] = '{4'b0000, 4'b1111, 1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0}; // reserved
      tbl[21] = '{4'b1111, 4'b1110, 1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b1}; // AL

      // ---------------- Reset ----------------
      idle();
      reset = 1'b1;
      FlagW = 2'b11; ALUFlags = 4'b1111;     // reset must override a write
      tick();
      tick();
      reset = 1'b0;
      idle();
      check("reset_flags", {28'd0, Flags}, 32'h0);
      check("reset_cnt", {16'd0, SquashCount}, 32'h0);
      Cond = 4'b0000; RegW = 1'b1;
      #1;
      check("rst_eq_condex", {31'd0, CondEx}, 32'd0);
      check("rst_eq_regwrite", {31'd0, RegWrite}, 32'd0);
      Cond = 4'b1110;
      #1;
      check("rst_al_condex", {31'd0, CondEx}, 32'd1);
      check("rst_al_regwrite", {31'd0, RegWrite}, 32'd1);

      // ---------------- One-cycle flag latency ----------------
      idle();
      FlagW = 2'b11; ALUFlags = 4'b0100;
      Cond = 4'b0000;
      #1;
      check("lat_old_flags_eq", {31'd0, CondEx}, 32'd0);
      Cond = 4'b1110;
      tick();
      idle();
      Cond = 4'b0000; MemW = 1'b1;
      #1;
      check("lat_flags", {28'd0, Flags}, 32'h4);
      check("lat_condex", {31'd0, CondEx}, 32'd1);
      check("lat_memwrite", {31'd0, MemWrite}, 32'd1);

      // ---------------- Split flag halves ----------------
      load_flags(4'b0000);
      FlagW = 2'b01; ALUFlags = 4'b1111;
      tick();
      idle();
      check("half_cv", {28'd0, Flags}, 32'h3);
      FlagW = 2'b10; ALUFlags = 4'b1000;
      tick();
      idle();
      check("half_nz", {28'd0, Flags}, 32'hB);

      // ---------------- Squash and stall ----------------
      load_flags(4'b0000);
      Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0100;
      tick();
      check("sq_flags_hold", {28'd0, Flags}, 32'h0);
      check("sq_cnt1", {16'd0, SquashCount}, cnt_exp(32'd1));
      Stall = 1'b1;
      tick();
      check("stall_cnt", {16'd0, SquashCount}, cnt_exp(32'd1));
      Cond = 4'b1110;                        // passing write, but stalled
      tick();
      check("stall_flags", {28'd0, Flags}, 32'h0);
      check("stall_gated", {31'd0, CondEx}, 32'd1);
      idle();

      // Five more squashes: 16-bit counter reaches 6, 2-bit saturates at 3.
      Cond = 4'b1111; RegW = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("sat_cnt16", {16'd0, SquashCount}, cnt_exp(32'd6));
      check("sat_cnt2", {30'd0, SquashCount2}, cnt_exp(32'd3));
      // No request strobes: not a squash.
      RegW = 1'b0;
      tick();
      check("noreq_cnt16", {16'd0, SquashCount}, cnt_exp(32'd6));
      // Mid-sequence reset clears, then counting resumes.
      RegW = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_cnt2", {30'd0, SquashCount2}, 32'd0);
      check("midrst_cnt16", {16'd0, SquashCount}, 32'd0);
      tick();
      check("post_rst_cnt2", {30'd0, SquashCount2}, cnt_exp(32'd1));
      idle();

      // ---------------- Condition table ----------------
      for (int i = 0; i < 22; i++) begin
         load_flags(tbl[i].flags);
         Cond    = tbl[i].cond;
         PCS     = tbl[i].pcs;
         RegW    = tbl[i].regw;
         MemW    = tbl[i].memw;
         NoWrite = tbl[i].nowr;
         #1;
         check($sformatf("v%0d_flags", i), {28'd0, Flags}, {28'd0, tbl[i].flags});
         check($sformatf("v%0d_condex", i), {31'd0, CondEx}, {31'd0, tbl[i].ex});
         check($sformatf("v%0d_pcsrc", i), {31'd0, PCSrc}, {31'd0, tbl[i].pcsrc});
         check($sformatf("v%0d_regwrite", i), {31'd0, RegWrite}, {31'd0, tbl[i].regwr});
         check($sformatf("v%0d_memwrite", i), {31'd0, MemWrite}, {31'd0, tbl[i].memwr});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
